// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin two-requester byte arbiter driving an 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_arbiter #(
    parameter int CLK_DIV = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       TXD,
    output logic       busy,
    output logic       grant_id
);
    localparam int CW = $clog2(CLK_DIV);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t      r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]  r_idx, w_idx;
    logic [7:0]  r_shift, w_shift;
    logic        r_txd, w_txd;
    logic        r_last, w_last;
    logic        r_grant, w_grant;
    logic        w_win, w_go, w_tick;
    assign TXD      = r_txd;
    assign busy     = r_state != IDLE;
    assign grant_id = r_grant;
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_shift <= w_shift;
            r_txd   <= w_txd;
            r_last  <= w_last;
            r_grant <= w_grant;
        end
    end
    // The shift register rotates so its XOR stays equal to the byte's parity.
    always_comb begin
        w_win      = (req0_valid && req1_valid) ? ~r_last : req1_valid;
        req0_ready = r_state == IDLE && !RST && req0_valid && !w_win;
        req1_ready = r_state == IDLE && !RST && req1_valid && w_win;
        w_go       = req0_ready || req1_ready;
        w_tick     = r_cnt == CW'(CLK_DIV - 1);
        w_state    = r_state;
        w_cnt      = (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
        w_idx      = r_idx;
        w_shift    = r_shift;
        w_txd      = r_txd;
        w_last     = r_last;
        w_grant    = r_grant;
        case (r_state)
            IDLE: if (w_go) begin
                w_state = START;
                w_shift = w_win ? req1_data : req0_data;
                w_idx   = '0;
                w_txd   = 1'b0;
                w_last  = w_win;
                w_grant = w_win;
            end
            START: if (w_tick) begin
                w_state = DATA;
                w_txd   = r_shift[0];
            end
            DATA: if (w_tick) begin
                if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state = PARITY;
                    w_txd   = ^r_shift;
`else
                    w_state = STOP;
                    w_txd   = 1'b1;
`endif
                end else begin
                    w_shift = {r_shift[0], r_shift[7:1]};
                    w_idx   = r_idx + 3'd1;
                    w_txd   = r_shift[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_tick) begin
                w_state = STOP;
                w_txd   = 1'b1;
            end
`endif
            STOP: if (w_tick) w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized frame checks against a bit-sequence reference model.
module tb_uart_tx_arbiter;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic clk = 1'b0, rst = 1'b1, v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic r0, r1, txd, busy, gid;
    logic m_last = 1'b1;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLK_DIV(D)) dut (
        .CLK(clk), .RST(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .TXD(txd), .busy(busy), .grant_id(gid)
    );

    // Serial bit i of a frame carrying byte b: start, 8 data LSB first, optional parity, stop.
    function automatic logic exp_bit(logic [7:0] b, int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && NB == 11) return ^b;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_chk(input logic g);
        chk("idle_txd", txd, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_grant", gid, g);
    endtask

    // Accept one byte in the current cycle and follow its whole frame.
    task automatic xfer(input int raise_at, input logic raise_id, input logic [7:0] raise_d, input int rst_at);
        logic w;
        logic [7:0] b;
        #1;
        w = (v0 && v1) ? !m_last : v1;
        b = w ? d1 : d0;
        chk("ready0", r0, w == 1'b0);
        chk("ready1", r1, w == 1'b1);
        m_last = w;
        for (int k = 0; k < NB * D; k++) begin
            tick();
            if (k == 0) begin
                if (w) v1 = 1'b0; else v0 = 1'b0;
            end
            if (k == raise_at) begin
                if (raise_id && !v1) begin v1 = 1'b1; d1 = raise_d; end
                if (!raise_id && !v0) begin v0 = 1'b1; d0 = raise_d; end
            end
            #1;
            chk("txd", txd, exp_bit(b, k / D));
            chk("busy", busy, 1'b1);
            chk("grant", gid, w);
            chk("hold0", r0, 1'b0);
            chk("hold1", r1, 1'b0);
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                #1;
                chk("rst_txd", txd, 1'b1);
                chk("rst_busy", busy, 1'b0);
                chk("rst_grant", gid, 1'b0);
                chk("rst_r0", r0, 1'b0);
                chk("rst_r1", r1, 1'b0);
                m_last = 1'b1;
                rst = 1'b0;
                return;
            end
        end
        tick();
        #1;
        idle_chk(w);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_chk(1'b0);
            chk("rst_r0", r0, 1'b0);
            chk("rst_r1", r1, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            idle_chk(1'b0);
            chk("quiet_r0", r0, 1'b0);
            chk("quiet_r1", r1, 1'b0);
        end
        v0 = 1'b1; d0 = 8'hA5;
        xfer(-1, 1'b0, 8'h00, -1);

        rst = 1'b1; m_last = 1'b1;
        v0 = 1'b1; d0 = 8'h55; v1 = 1'b1; d1 = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("tie_rst_r0", r0, 1'b0);
            chk("tie_rst_r1", r1, 1'b0);
        end
        tick();
        rst = 1'b0;
        xfer(0, 1'b0, 8'h5A, -1);
        xfer(0, 1'b1, 8'hF0, -1);
        xfer(-1, 1'b0, 8'h00, -1);
        xfer(-1, 1'b0, 8'h00, -1);

        v0 = 1'b1; d0 = 8'($urandom);
        xfer(17, 1'b1, 8'hC3, -1);
        xfer(-1, 1'b0, 8'h00, -1);

        v0 = 1'b1; d0 = 8'h96;
        xfer(-1, 1'b0, 8'h00, 15);
        v0 = 1'b1; d0 = 8'h69; v1 = 1'b1; d1 = 8'h3C;
        xfer(-1, 1'b0, 8'h00, -1);
        xfer(-1, 1'b0, 8'h00, -1);

        v0 = 1'b1; d0 = 8'h07;
        xfer(-1, 1'b0, 8'h00, -1);
        v0 = 1'b1; d0 = 8'h03;
        xfer(-1, 1'b0, 8'h00, -1);

        for (int n = 0; n < 24; n++) begin
            if (!v0 && $urandom_range(0, 1) == 1) begin v0 = 1'b1; d0 = 8'($urandom); end
            if (!v1 && $urandom_range(0, 1) == 1) begin v1 = 1'b1; d1 = 8'($urandom); end
            if (!v0 && !v1) begin v1 = 1'b1; d1 = 8'($urandom); end
            xfer($urandom_range(0, NB * D - 1), 1'($urandom_range(0, 1)), 8'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
